// File: rtl/display_mode_ctrl.sv
// Display view sequencer: steps HOUR -> DATE -> YEAR on a button press
// (manual mode) or on a tick-driven dwell timer (auto mode), and drives
// one-hot registered select lines for the digit mux.
module display_mode_ctrl #(
    parameter int unsigned HOLD_HOUR    = 10,
    parameter int unsigned HOLD_DATE    = 3,
    parameter int unsigned HOLD_YEAR    = 3,
    parameter int unsigned RETURN_TICKS = 5,
    parameter int unsigned CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       btn_mode,
    input  logic       auto_en,
    output logic       hour_en,
    output logic       day_en,
    output logic       mon_en,
    output logic       year_en,
    output logic [1:0] mode
);

    typedef enum logic [1:0] {
        ST_HOUR = 2'd0,
        ST_DATE = 2'd1,
        ST_YEAR = 2'd2,
        ST_BAD  = 2'd3
    } state_t;

    // A hold of zero would never match the counter, so it behaves as one.
    localparam int unsigned HH = (HOLD_HOUR == 0) ? 1 : HOLD_HOUR;
    localparam int unsigned HD = (HOLD_DATE == 0) ? 1 : HOLD_DATE;
    localparam int unsigned HY = (HOLD_YEAR == 0) ? 1 : HOLD_YEAR;
    localparam int unsigned HR = (RETURN_TICKS == 0) ? 1 : RETURN_TICKS;

    localparam logic [CNT_W-1:0] LIM_HOUR = CNT_W'(HH - 1);
    localparam logic [CNT_W-1:0] LIM_DATE = CNT_W'(HD - 1);
    localparam logic [CNT_W-1:0] LIM_YEAR = CNT_W'(HY - 1);
    localparam logic [CNT_W-1:0] LIM_RET  = CNT_W'(HR - 1);
    localparam logic             RET_EN   = (RETURN_TICKS != 0);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               b1_q, b2_q, b3_q;
    logic               auto_q;

    logic               press;
    logic               auto_chg;
    state_t             state_adv;
    logic [CNT_W-1:0]   lim_auto;

    assign press    = b2_q & ~b3_q;
    assign auto_chg = (auto_en != auto_q);

    // Successor view and auto-mode dwell limit for the current view.
    always_comb begin
        state_adv = ST_HOUR;
        lim_auto  = LIM_HOUR;
        case (state_q)
            ST_HOUR: begin state_adv = ST_DATE; lim_auto = LIM_HOUR; end
            ST_DATE: begin state_adv = ST_YEAR; lim_auto = LIM_DATE; end
            ST_YEAR: begin state_adv = ST_HOUR; lim_auto = LIM_YEAR; end
            default: begin state_adv = ST_HOUR; lim_auto = LIM_HOUR; end
        endcase
    end

    // Next state and dwell counter; press outranks timer expiry, and an
    // auto_en toggle only restarts the dwell without moving the view.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_BAD) begin
            state_d = ST_HOUR;
            cnt_d   = '0;
        end else if (press) begin
            state_d = state_adv;
            cnt_d   = '0;
        end else if (auto_chg) begin
            cnt_d   = '0;
        end else if (tick && auto_en && (cnt_q == lim_auto)) begin
            state_d = state_adv;
            cnt_d   = '0;
        end else if (tick && !auto_en && RET_EN && (state_q != ST_HOUR)
                     && (cnt_q == LIM_RET)) begin
            state_d = ST_HOUR;
            cnt_d   = '0;
        end else if (tick && (cnt_q != '1)) begin
            cnt_d   = cnt_q + CNT_W'(1);
        end
    end

    // Button synchroniser, auto_en history, state, dwell and decoded selects.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b1_q    <= 1'b1;
            b2_q    <= 1'b1;
            b3_q    <= 1'b1;
            auto_q  <= 1'b0;
            state_q <= ST_HOUR;
            cnt_q   <= '0;
            hour_en <= 1'b1;
            day_en  <= 1'b0;
            mon_en  <= 1'b0;
            year_en <= 1'b0;
            mode    <= 2'd0;
        end else begin
            b1_q    <= btn_mode;
            b2_q    <= b1_q;
            b3_q    <= b2_q;
            auto_q  <= auto_en;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hour_en <= (state_d == ST_HOUR);
            day_en  <= (state_d == ST_DATE);
            mon_en  <= 1'b0;
            year_en <= (state_d == ST_YEAR);
            mode    <= state_d;
        end
    end

endmodule

// File: tb/tb_display_mode_ctrl.sv
// Bench for display_mode_ctrl: directed scenarios with literal expectations,
// then randomized button/tick/auto traffic, all checked every cycle against a
// view-level model of the sequencer.
module tb_display_mode_ctrl;

    localparam int H_HOUR = 10;
    localparam int H_DATE = 3;
    localparam int H_YEAR = 3;
    localparam int RET    = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       btn_mode = 1'b0;
    logic       auto_en = 1'b0;
    logic       hour_en, day_en, mon_en, year_en;
    logic [1:0] mode;

    int n_tests = 0;
    int n_fail  = 0;

    display_mode_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .btn_mode (btn_mode),
        .auto_en  (auto_en),
        .hour_en  (hour_en),
        .day_en   (day_en),
        .mon_en   (mon_en),
        .year_en  (year_en),
        .mode     (mode)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // View index 0/1/2 = HOUR/DATE/YEAR, dwell in ticks, and the last three
    // samples of the button (newest first) from which a press is a rising
    // edge seen two samples late.
    int m_view = 0;
    int m_cnt  = 0;
    bit m_auto = 0;
    bit smp[3] = '{1, 1, 1};

    function automatic int hold_of(input int v);
        case (v)
            0:       return H_HOUR;
            1:       return H_DATE;
            default: return H_YEAR;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        int  nv, nc;
        bit  pr;
        if (rst) begin
            m_view <= 0;
            m_cnt  <= 0;
            m_auto <= 0;
            smp    <= '{1, 1, 1};
        end else begin
            nv = m_view;
            nc = m_cnt;
            pr = smp[1] && !smp[2];
            if (pr) begin
                nv = (m_view + 1) % 3;
                nc = 0;
            end else if (auto_en != m_auto) begin
                nc = 0;
            end else if (tick && auto_en && m_cnt == hold_of(m_view) - 1) begin
                nv = (m_view + 1) % 3;
                nc = 0;
            end else if (tick && !auto_en && m_view != 0 && m_cnt == RET - 1) begin
                nv = 0;
                nc = 0;
            end else if (tick && m_cnt < 255) begin
                nc = m_cnt + 1;
            end
            m_view <= nv;
            m_cnt  <= nc;
            m_auto <= auto_en;
            smp    <= '{btn_mode, smp[0], smp[1]};
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (!rst) begin
            check("cyc_hour_en", hour_en, int'(m_view == 0));
            check("cyc_day_en",  day_en,  int'(m_view == 1));
            check("cyc_year_en", year_en, int'(m_view == 2));
            check("cyc_mon_en",  mon_en,  0);
            check("cyc_mode",    mode,    m_view);
            check("cyc_onehot",  hour_en + day_en + mon_en + year_en, 1);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic clks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_ticks(input int n);
        repeat (n) begin
            tick = 1'b1;
            clks(1);
            tick = 1'b0;
            clks(1);
        end
    endtask

    task automatic press_btn();
        btn_mode = 1'b1;
        clks(5);
        btn_mode = 1'b0;
        clks(4);
    endtask

    initial begin
        int  hold;
        bit  lvl;
        hold = 0;
        lvl  = 0;

        // 1: reset state, then idle with ticks
        clks(2);
        check("rst_hour_en", hour_en, 1);
        check("rst_day_en",  day_en,  0);
        check("rst_mon_en",  mon_en,  0);
        check("rst_year_en", year_en, 0);
        check("rst_mode",    mode,    0);
        rst = 1'b0;
        repeat (50) begin
            tick = 1'b1;
            clks(1);
            tick = 1'b0;
            clks(3);
        end
        check("idle_mode", mode, 0);
        check("idle_hour_en", hour_en, 1);

        // 2: manual press latency, single step for a held button
        btn_mode = 1'b1;
        clks(1);
        check("press_edge_k", mode, 0);
        clks(1);
        check("press_edge_k1", mode, 0);
        clks(1);
        check("press_edge_k2_mode", mode, 1);
        check("press_edge_k2_day", day_en, 1);
        clks(2);
        btn_mode = 1'b0;
        clks(4);
        check("held_one_step", mode, 1);
        press_btn();
        check("press2_year_en", year_en, 1);
        press_btn();
        check("press3_hour_en", hour_en, 1);

        // 3: manual return from YEAR after RETURN_TICKS ticks
        press_btn();
        press_btn();
        check("ret_in_year", mode, 2);
        do_ticks(RET - 1);
        check("ret_4_ticks_year", year_en, 1);
        do_ticks(1);
        check("ret_5_ticks_hour", hour_en, 1);
        check("ret_5_ticks_mode", mode, 0);

        // 4: auto rotation 10/3/3
        auto_en = 1'b1;
        clks(2);
        do_ticks(H_HOUR - 1);
        check("auto_hour_9", mode, 0);
        do_ticks(1);
        check("auto_date", mode, 1);
        do_ticks(H_DATE - 1);
        check("auto_date_2", mode, 1);
        do_ticks(1);
        check("auto_year", mode, 2);
        do_ticks(H_YEAR - 1);
        check("auto_year_2", mode, 2);
        do_ticks(1);
        check("auto_hour_wrap", mode, 0);

        // 5: press and dwell expiry on the same edge advance once
        do_ticks(H_HOUR);
        check("coll_in_date", mode, 1);
        do_ticks(2);
        btn_mode = 1'b1;
        clks(1);
        clks(1);
        tick = 1'b1;
        clks(1);
        tick = 1'b0;
        check("coll_year", mode, 2);
        clks(2);
        btn_mode = 1'b0;
        clks(4);
        do_ticks(H_YEAR - 1);
        check("coll_year_after2", mode, 2);
        do_ticks(1);
        check("coll_hour_after3", mode, 0);

        // 6: asynchronous reset between edges while in YEAR, button held
        auto_en = 1'b0;
        clks(2);
        press_btn();
        press_btn();
        check("arst_pre_year", mode, 2);
        @(posedge clk);
        #2;
        rst      = 1'b1;
        btn_mode = 1'b1;
        #2;
        check("arst_imm_hour_en", hour_en, 1);
        check("arst_imm_year_en", year_en, 0);
        check("arst_imm_mode",    mode,    0);
        #2;
        rst = 1'b0;
        clks(8);
        check("arst_held_no_step", mode, 0);
        btn_mode = 1'b0;
        clks(4);

        // randomized traffic, checked by the every-cycle comparison
        repeat (3000) begin
            if (hold == 0) begin
                lvl  = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 8);
            end
            hold--;
            btn_mode = lvl;
            tick     = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 99) == 0)
                auto_en = ~auto_en;
            clks(1);
        end
        tick     = 1'b0;
        btn_mode = 1'b0;
        clks(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
